// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: walks one instruction through FETCH/DECODE/EXECUTE/MEM/WB
// and decodes every datapath strobe from the current state and the IR opcode.
module multicycle_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_code,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_en,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic [4:0]  ALUControl,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        Branch,
  output logic [1:0]  PCSrc,
  output logic        illegal,
  output logic        retire
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;

  state_t      r_state;
  state_t      w_next;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic        w_is_op, w_is_op_imm, w_is_load, w_is_store, w_is_branch;
  logic        w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
  logic        w_exec_src_a, w_exec_src_b;
  logic [4:0]  w_exec_alu;
  logic        w_unused;

  assign w_opcode   = instruction_code[6:0];
  assign w_funct3   = instruction_code[14:12];
  assign w_funct7_5 = instruction_code[30];
  assign w_unused   = ^{instruction_code[31], instruction_code[29:15], instruction_code[11:7]};

  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_is_op_imm = (w_opcode == OPC_OP_IMM);
  assign w_is_load   = (w_opcode == OPC_LOAD);
  assign w_is_store  = (w_opcode == OPC_STORE);
  assign w_is_branch = (w_opcode == OPC_BRANCH);
  assign w_is_jal    = (w_opcode == OPC_JAL);
  assign w_is_jalr   = (w_opcode == OPC_JALR);
  assign w_is_lui    = (w_opcode == OPC_LUI);
  assign w_is_auipc  = (w_opcode == OPC_AUIPC);
  assign w_legal     = w_is_op | w_is_op_imm | w_is_load | w_is_store | w_is_branch |
                       w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

  // Operand selects and ALU op chosen in EXECUTE; WB re-drives them so ALU_result stays valid.
  assign w_exec_src_a = w_is_auipc;
  assign w_exec_src_b = w_is_op_imm | w_is_load | w_is_store | w_is_jalr | w_is_auipc;

  always_comb begin
    w_exec_alu = ALU_ADD;
    if (w_is_op)
      w_exec_alu = {1'b0, w_funct7_5, w_funct3};
    else if (w_is_op_imm)
      w_exec_alu = {1'b0, w_funct7_5 & (w_funct3 == 3'b101), w_funct3};
    else if (w_is_branch)
      w_exec_alu = ALU_SUB;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_en      = 1'b0;
    ALUSrc_A   = 1'b0;
    ALUSrc_B   = 1'b0;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    MemtoReg   = 2'b00;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          illegal = 1'b1;
          pc_en   = 1'b1;
          retire  = 1'b1;
          w_next  = S_FETCH;
        end else begin
          w_next  = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        ALUSrc_A   = w_exec_src_a;
        ALUSrc_B   = w_exec_src_b;
        ALUControl = w_exec_alu;
        if (w_is_branch) begin
          Branch = 1'b1;
          pc_en  = 1'b1;
          retire = 1'b1;
          PCSrc  = branch_taken ? 2'b01 : 2'b00;
          w_next = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = w_is_store;
        ALUSrc_B   = 1'b1;
        ALUControl = ALU_ADD;
        if (dmem_ready) begin
          if (w_is_store) begin
            pc_en  = 1'b1;
            retire = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        ALUSrc_A   = w_exec_src_a;
        ALUSrc_B   = w_exec_src_b;
        ALUControl = w_exec_alu;
        RegWrite   = 1'b1;
        pc_en      = 1'b1;
        retire     = 1'b1;
        w_next     = S_FETCH;
        if (w_is_load) begin
          MemtoReg = 2'b01;
        end else if (w_is_jal) begin
          MemtoReg = 2'b10;
          PCSrc    = 2'b10;
        end else if (w_is_jalr) begin
          MemtoReg = 2'b10;
          PCSrc    = 2'b11;
        end else if (w_is_lui) begin
          MemtoReg = 2'b11;
        end
      end
      default: w_next = S_FETCH;
    endcase

    // Reset silences every strobe, so an interrupted access never commits.
    if (rst) begin
      imem_req   = 1'b0;
      ir_en      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_en      = 1'b0;
      ALUSrc_A   = 1'b0;
      ALUSrc_B   = 1'b0;
      ALUControl = ALU_ADD;
      RegWrite   = 1'b0;
      MemtoReg   = 2'b00;
      Branch     = 1'b0;
      PCSrc      = 2'b00;
      illegal    = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle bench for multicycle_control_unit: each directed step pushes the full
// expected output vector, which is popped and compared on the following falling edge.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_code;
  logic        imem_ready, dmem_ready, branch_taken;
  logic        imem_req, ir_en, dmem_req, dmem_we, pc_en, ALUSrc_A, ALUSrc_B;
  logic [4:0]  ALUControl;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        Branch;
  logic [1:0]  PCSrc;
  logic        illegal, retire;

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instruction_code(instruction_code),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_en(pc_en), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch), .PCSrc(PCSrc),
    .illegal(illegal), .retire(retire)
  );

  assign obs = {imem_req, ir_en, dmem_req, dmem_we, pc_en, ALUSrc_A, ALUSrc_B, ALUControl,
                RegWrite, MemtoReg, Branch, PCSrc, illegal, retire};

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D193;
  localparam logic [31:0] I_ADDIN = 32'hC0008193;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_AUIPC = 32'h00001297;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [19:0] Z       = 20'h00000;

  function automatic logic [19:0] ov(input logic imr, input logic ire, input logic dr,
                                     input logic dwe, input logic pce, input logic sa,
                                     input logic sb, input logic [4:0] alu, input logic rw,
                                     input logic [1:0] m2r, input logic br,
                                     input logic [1:0] pcs, input logic ill, input logic ret);
    return {imr, ire, dr, dwe, pce, sa, sb, alu, rw, m2r, br, pcs, ill, ret};
  endfunction

  task automatic step(input string tag, input logic r, input logic [31:0] ic, input logic ir,
                      input logic dr, input logic bt, input logic [19:0] e);
    logic [19:0] exp_v;
    rst = r; instruction_code = ic; imem_ready = ir; dmem_ready = dr; branch_taken = bt;
    exp_q.push_back(e);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: every output low, including imem_req.
    step("rst.0", 1, I_ADD, 1, 1, 1, Z);
    step("rst.1", 1, I_ADD, 1, 1, 1, Z);

    // add x3,x1,x2, zero-wait: 4 cycles.
    step("add.fetch",  0, I_ADD, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("add.decode", 0, I_ADD, 1, 0, 0, Z);
    step("add.exec",   0, I_ADD, 1, 0, 0, Z);
    step("add.wb",     0, I_ADD, 1, 0, 0, ov(0,0,0,0,1,0,0,5'b00000,1,2'b00,0,2'b00,0,1));

    // sub: funct7[5] reaches ALUControl.
    step("sub.fetch",  0, I_SUB, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("sub.decode", 0, I_SUB, 1, 0, 0, Z);
    step("sub.exec",   0, I_SUB, 1, 0, 0, ov(0,0,0,0,0,0,0,5'b01000,0,2'b00,0,2'b00,0,0));
    step("sub.wb",     0, I_SUB, 1, 0, 0, ov(0,0,0,0,1,0,0,5'b01000,1,2'b00,0,2'b00,0,1));

    // srai with one imem wait cycle.
    step("srai.fwait", 0, I_SRAI, 0, 1, 0, ov(1,0,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("srai.fetch", 0, I_SRAI, 1, 1, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("srai.decode",0, I_SRAI, 1, 1, 0, Z);
    step("srai.exec",  0, I_SRAI, 1, 1, 0, ov(0,0,0,0,0,0,1,5'b01101,0,2'b00,0,2'b00,0,0));
    step("srai.wb",    0, I_SRAI, 1, 1, 0, ov(0,0,0,0,1,0,1,5'b01101,1,2'b00,0,2'b00,0,1));

    // addi with imm bit 30 set but funct3 != 101: stays ADD.
    step("addi.fetch", 0, I_ADDIN, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("addi.decode",0, I_ADDIN, 1, 0, 0, Z);
    step("addi.exec",  0, I_ADDIN, 1, 0, 0, ov(0,0,0,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("addi.wb",    0, I_ADDIN, 1, 0, 0, ov(0,0,0,0,1,0,1,5'b00000,1,2'b00,0,2'b00,0,1));

    // lw with dmem_ready low for 2 cycles (high elsewhere, must be ignored): 7 cycles.
    step("lw.fetch",   0, I_LW, 1, 1, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("lw.decode",  0, I_LW, 1, 1, 0, Z);
    step("lw.exec",    0, I_LW, 1, 1, 0, ov(0,0,0,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("lw.mwait0",  0, I_LW, 1, 0, 0, ov(0,0,1,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("lw.mwait1",  0, I_LW, 1, 0, 0, ov(0,0,1,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("lw.mem",     0, I_LW, 1, 1, 0, ov(0,0,1,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("lw.wb",      0, I_LW, 1, 1, 0, ov(0,0,0,0,1,0,1,5'b00000,1,2'b01,0,2'b00,0,1));

    // sw: retires on the dmem_ready cycle, never writes the register file.
    step("sw.fetch",   0, I_SW, 1, 1, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("sw.decode",  0, I_SW, 1, 1, 0, Z);
    step("sw.exec",    0, I_SW, 1, 1, 0, ov(0,0,0,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("sw.mem",     0, I_SW, 1, 1, 0, ov(0,0,1,1,1,0,1,5'b00000,0,2'b00,0,2'b00,0,1));

    // beq taken, then not taken: 3 cycles each.
    step("beq1.fetch", 0, I_BEQ, 1, 1, 1, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("beq1.decode",0, I_BEQ, 1, 1, 1, Z);
    step("beq1.exec",  0, I_BEQ, 1, 1, 1, ov(0,0,0,0,1,0,0,5'b01000,0,2'b00,1,2'b01,0,1));
    step("beq0.fetch", 0, I_BEQ, 1, 1, 1, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("beq0.decode",0, I_BEQ, 1, 1, 1, Z);
    step("beq0.exec",  0, I_BEQ, 1, 1, 0, ov(0,0,0,0,1,0,0,5'b01000,0,2'b00,1,2'b00,0,1));

    // jalr, jal, lui, auipc write-back variants.
    step("jalr.fetch", 0, I_JALR, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("jalr.decode",0, I_JALR, 1, 0, 0, Z);
    step("jalr.exec",  0, I_JALR, 1, 0, 0, ov(0,0,0,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("jalr.wb",    0, I_JALR, 1, 0, 0, ov(0,0,0,0,1,0,1,5'b00000,1,2'b10,0,2'b11,0,1));
    step("jal.fetch",  0, I_JAL, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("jal.decode", 0, I_JAL, 1, 0, 0, Z);
    step("jal.exec",   0, I_JAL, 1, 0, 0, Z);
    step("jal.wb",     0, I_JAL, 1, 0, 0, ov(0,0,0,0,1,0,0,5'b00000,1,2'b10,0,2'b10,0,1));
    step("lui.fetch",  0, I_LUI, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("lui.decode", 0, I_LUI, 1, 0, 0, Z);
    step("lui.exec",   0, I_LUI, 1, 0, 0, Z);
    step("lui.wb",     0, I_LUI, 1, 0, 0, ov(0,0,0,0,1,0,0,5'b00000,1,2'b11,0,2'b00,0,1));
    step("auipc.fetch",0, I_AUIPC, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("auipc.decode",0,I_AUIPC, 1, 0, 0, Z);
    step("auipc.exec", 0, I_AUIPC, 1, 0, 0, ov(0,0,0,0,0,1,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("auipc.wb",   0, I_AUIPC, 1, 0, 0, ov(0,0,0,0,1,1,1,5'b00000,1,2'b00,0,2'b00,0,1));

    // Unsupported opcode: 2 cycles, illegal pulse in DECODE, no RegWrite.
    step("ill.fetch",  0, I_ILL, 1, 1, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("ill.decode", 0, I_ILL, 1, 1, 0, ov(0,0,0,0,1,0,0,5'b00000,0,2'b00,0,2'b00,1,1));

    // Reset during a MEM wait abandons the load.
    step("rlw.fetch",  0, I_LW, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("rlw.decode", 0, I_LW, 1, 0, 0, Z);
    step("rlw.exec",   0, I_LW, 1, 0, 0, ov(0,0,0,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("rlw.mwait",  0, I_LW, 1, 0, 0, ov(0,0,1,0,0,0,1,5'b00000,0,2'b00,0,2'b00,0,0));
    step("rlw.rst",    1, I_LW, 1, 1, 0, Z);
    // Restart in FETCH, then reset again mid-FETCH.
    step("rf.fwait",   0, I_LW, 0, 1, 0, ov(1,0,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("rf.rst",     1, I_LW, 1, 1, 0, Z);
    step("post.fetch", 0, I_ADD, 1, 0, 0, ov(1,1,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));
    step("post.decode",0, I_ADD, 1, 0, 0, Z);
    step("post.exec",  0, I_ADD, 1, 0, 0, Z);
    step("post.wb",    0, I_ADD, 1, 0, 0, ov(0,0,0,0,1,0,0,5'b00000,1,2'b00,0,2'b00,0,1));
    step("post.next",  0, I_ADD, 0, 0, 0, ov(1,0,0,0,0,0,0,5'b00000,0,2'b00,0,2'b00,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
